// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-coherent shadow update,
// anti-ghost blank window and leading-zero suppression. Optional macro: SEG_DP_EN.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned DIV        = 100000,
  parameter int unsigned BLANK      = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   iSeg,
  input  logic                  iWe,
  input  logic                  iLzb,
`ifdef SEG_DP_EN
  input  logic [DIGITS-1:0]     iDp,
`endif
  output logic [DIGITS-1:0]     oAn,
  output logic [7:0]            oSeg
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  LAST_DIV = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_C  = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]        SEG_OFF  = {8{ACTIVE_LOW}};

  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] r_display;
  logic [CNT_W-1:0]    r_div_cnt;
  logic [IDX_W-1:0]    r_idx;

  logic                w_wrap;
  logic                w_frame_end;
  logic [3:0]          w_nib;
  logic [IDX_W-1:0]    w_msd;
  logic                w_dp;
  logic [DIGITS-1:0]   w_an_hot;
  logic                w_dark;
  logic [DIGITS-1:0]   w_an_next;
  logic [7:0]          w_seg_next;

  // Active-high hex decode, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_wrap      = (r_div_cnt == LAST_DIV);
  assign w_frame_end = w_wrap && (r_idx == LAST_IDX);

  always_comb begin
    w_nib    = 4'h0;
    w_msd    = '0;
    w_an_hot = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib       = r_display[4*k +: 4];
        w_an_hot[k] = 1'b1;
      end
      // Ascending scan: the last nonzero nibble seen is the most significant one
      if (r_display[4*k +: 4] != 4'h0) w_msd = IDX_W'(k);
    end
  end

`ifdef SEG_DP_EN
  logic [DIGITS-1:0] r_dp_shadow;
  logic [DIGITS-1:0] r_dp_display;

  always_comb begin
    w_dp = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++)
      if (r_idx == IDX_W'(k)) w_dp = r_dp_display[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp_shadow  <= '0;
      r_dp_display <= '0;
    end else begin
      if (w_frame_end) r_dp_display <= r_dp_shadow;
      if (iWe)         r_dp_shadow  <= iDp;
    end
  end
`else
  assign w_dp = 1'b0;
`endif

  // Dark slot: inside the anti-ghost window, or a suppressed leading zero
  assign w_dark     = (r_div_cnt < BLANK_C) || (iLzb && (r_idx > w_msd));
  assign w_an_next  = w_dark ? AN_OFF  : (w_an_hot ^ AN_OFF);
  assign w_seg_next = w_dark ? SEG_OFF : ({w_dp, hex7(w_nib)} ^ SEG_OFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_display <= '0;
      r_div_cnt <= '0;
      r_idx     <= '0;
      oAn       <= AN_OFF;
      oSeg      <= SEG_OFF;
    end else begin
      if (iWe)         r_shadow  <= iSeg;
      if (w_frame_end) r_display <= r_shadow;
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_idx     <= (r_idx == LAST_IDX) ? '0 : IDX_W'(r_idx + 1'b1);
      end else begin
        r_div_cnt <= CNT_W'(r_div_cnt + 1'b1);
      end
      oAn  <= w_an_next;
      oSeg <= w_seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=4, DIV=4, BLANK=1, ACTIVE_LOW=1)
// against a cycle-count based frame model.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] iSeg = 16'h0;
  logic        iWe = 1'b0;
  logic        iLzb = 1'b0;
  logic [3:0]  iDp = 4'h0;
  logic [3:0]  oAn;
  logic [7:0]  oSeg;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset release, shadow/display value and dp
  int          t;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_dps, m_dpd;
  logic [3:0]  g_dp = 4'h0;

  logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_ctrl #(.DIGITS(4), .DIV(4), .BLANK(1), .ACTIVE_LOW(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .iSeg (iSeg),
    .iWe  (iWe),
    .iLzb (iLzb),
`ifdef SEG_DP_EN
    .iDp  (iDp),
`endif
    .oAn  (oAn),
    .oSeg (oSeg)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, predict the registered outputs, advance the model, compare
  task automatic tick(input logic we, input logic [15:0] val);
    int         phase, slot, msd;
    logic       lit;
    logic       dpbit;
    logic [3:0] nib;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    iWe  = we;
    iSeg = val;
    iDp  = g_dp;
    phase = t % 4;
    slot  = (t / 4) % 4;
    msd   = 0;
    for (int k = 0; k < 4; k++) if (m_disp[4*k +: 4] != 4'h0) msd = k;
    lit   = (phase >= 1) && !(iLzb && slot > msd);
    nib   = m_disp[4*slot +: 4];
`ifdef SEG_DP_EN
    dpbit = m_dpd[slot];
`else
    dpbit = 1'b0;
`endif
    exp_an = 4'hF;
    if (lit) exp_an[slot] = 1'b0;
    exp_seg = lit ? ~{dpbit, HEX[nib]} : 8'hFF;
    if (t % 16 == 15) begin
      m_disp = m_shadow;
      m_dpd  = m_dps;
    end
    if (we) begin
      m_shadow = val;
      m_dps    = g_dp;
    end
    t++;
    @(posedge clk);
    #1;
    iWe = 1'b0;
    checks++;
    if (oAn !== exp_an) begin
      errors++;
      $display("FAIL oAn cycle=%0d got=%h exp=%h", t, oAn, exp_an);
    end
    if (phase < 1 || lit) begin
      checks++;
      if (oSeg !== exp_seg) begin
        errors++;
        $display("FAIL oSeg cycle=%0d got=%h exp=%h", t, oSeg, exp_seg);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0);
  endtask

  task automatic align(input int phase16);
    int guard = 0;
    while ((t % 16) != phase16 && guard < 32) begin
      tick(1'b0, 16'h0);
      guard++;
    end
  endtask

  task automatic model_reset();
    t        = 0;
    m_shadow = 16'h0;
    m_disp   = 16'h0;
    m_dps    = 4'h0;
    m_dpd    = 4'h0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (oAn !== 4'hF || oSeg !== 8'hFF) begin
      errors++;
      $display("FAIL reset_state got an=%h seg=%h exp an=f seg=ff", oAn, oSeg);
    end
    rst = 1'b0;
    model_reset();
    // First slot: blank cycle, then digit 0 lit with 0
    run(2);
    checks++;
    if (oAn !== 4'hE || oSeg !== 8'hC0) begin
      errors++;
      $display("FAIL first_lit got an=%h seg=%h exp an=e seg=c0", oAn, oSeg);
    end
    run(14);
  endtask

  task automatic test_scan();
    tick(1'b1, 16'h1234);
    run(40);
  endtask

  task automatic test_tear();
    align(6);
    tick(1'b1, 16'hAAAA);
    run(40);
  endtask

  task automatic test_collision();
    tick(1'b1, 16'h0F0F);
    align(15);
    tick(1'b1, 16'h5555);
    run(48);
  endtask

  task automatic test_lzb();
    iLzb = 1'b1;
    tick(1'b1, 16'h0070);
    run(40);
    tick(1'b1, 16'h0000);
    run(40);
    iLzb = 1'b0;
  endtask

  task automatic test_dp();
    g_dp = 4'b0010;
    tick(1'b1, 16'h1234);
    run(40);
    g_dp = 4'b0000;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ((i % 11) == 0) iLzb = 1'($urandom_range(0, 1));
      g_dp = 4'($urandom);
      if ($urandom_range(0, 6) == 0)
        tick(1'b1, 16'($urandom) >> (4 * $urandom_range(0, 3)));
      else
        tick(1'b0, 16'h0);
    end
    iLzb = 1'b0;
  endtask

  task automatic test_reset_midslot();
    tick(1'b1, 16'h9876);
    align(9);
    run(1);
    rst = 1'b1;
    #1;
    checks++;
    if (oAn !== 4'hF || oSeg !== 8'hFF) begin
      errors++;
      $display("FAIL midslot_reset got an=%h seg=%h exp an=f seg=ff", oAn, oSeg);
    end
    @(posedge clk);
    #1;
    checks++;
    if (oAn !== 4'hF || oSeg !== 8'hFF) begin
      errors++;
      $display("FAIL reset_hold got an=%h seg=%h exp an=f seg=ff", oAn, oSeg);
    end
    rst = 1'b0;
    model_reset();
    run(34);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_tear();
    test_collision();
    test_lzb();
    test_dp();
    test_random();
    test_reset_midslot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
